// File: rtl/relogio_pkg.sv
// Shared types, field limits and wrap-around arithmetic for the clock
// control sequencer.
package relogio_pkg;

  localparam int H_W = 5;
  localparam int M_W = 6;
  localparam int S_W = 6;

  localparam logic [H_W-1:0] MAX_H = 5'd23;
  localparam logic [M_W-1:0] MAX_M = 6'd59;
  localparam logic [S_W-1:0] MAX_S = 6'd59;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SET_H,
    ST_SET_M,
    ST_SET_S,
    ST_COMMIT
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_H    = 2'd1,
    SEL_M    = 2'd2,
    SEL_S    = 2'd3
  } edit_sel_e;

  typedef struct packed {
    logic [H_W-1:0] h;
    logic [M_W-1:0] m;
    logic [S_W-1:0] s;
  } hms_t;

  // Out-of-range snapshots fold back into range on the first edit.
  function automatic logic [H_W-1:0] step_h(input logic [H_W-1:0] v,
                                            input logic           up);
    if (up) return (v >= MAX_H) ? '0 : v + H_W'(1);
    else    return (v == '0 || v > MAX_H) ? MAX_H : v - H_W'(1);
  endfunction

  function automatic logic [M_W-1:0] step_ms(input logic [M_W-1:0] v,
                                             input logic [M_W-1:0] max_v,
                                             input logic           up);
    if (up) return (v >= max_v) ? '0 : v + M_W'(1);
    else    return (v == '0 || v > max_v) ? max_v : v - M_W'(1);
  endfunction

  function automatic logic is_set(input state_e st);
    return (st == ST_SET_H) || (st == ST_SET_M) || (st == ST_SET_S);
  endfunction

endpackage

// File: rtl/relogio_ctrl_if.sv
// Button, time-snapshot and load/display signals between the front-end,
// the control sequencer and the timekeeping counter.
interface relogio_ctrl_if;
  import relogio_pkg::*;

  logic           mode_i;
  logic           inc_i;
  logic           dec_i;
  logic [H_W-1:0] time_h_i;
  logic [M_W-1:0] time_m_i;
  logic [S_W-1:0] time_s_i;

  logic           tick_o;
  logic           load_o;
  logic [H_W-1:0] load_h_o;
  logic [M_W-1:0] load_m_o;
  logic [S_W-1:0] load_s_o;
  logic [1:0]     edit_sel_o;
  logic           blink_o;

  modport master (
    output mode_i, inc_i, dec_i, time_h_i, time_m_i, time_s_i,
    input  tick_o, load_o, load_h_o, load_m_o, load_s_o, edit_sel_o, blink_o
  );

  modport slave (
    input  mode_i, inc_i, dec_i, time_h_i, time_m_i, time_s_i,
    output tick_o, load_o, load_h_o, load_m_o, load_s_o, edit_sel_o, blink_o
  );

endinterface

// File: rtl/relogio_prescaler.sv
// Modulo-DIV cycle counter; pulse_o marks the last count while enabled.
// clr_i wins over en_i and parks the count at zero.
module relogio_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic pulse_o
);

  localparam int           W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TOP = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_top;

  assign at_top = (cnt_q == TOP);

  // NOTE: default first so every path assigns cnt_d; no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_top ? '0 : cnt_q + W'(1);
    end
  end

  // NOTE: non-blocking so every flop samples pre-edge values together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign pulse_o = en_i & at_top;

endmodule

// File: rtl/relogio_ctrl.sv
// Clock control: 1 Hz advance enable in RUN, and a button-driven
// hours/minutes/seconds edit sequence committed with one load strobe.
module relogio_ctrl
  import relogio_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int BLINK_HZ = 2
) (
  input logic           clk_i,
  input logic           rst_i,
  relogio_ctrl_if.slave bus
);

  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);

  state_e    state_q, state_d;
  hms_t      shadow_q, shadow_d;
  logic      blink_q, blink_d;
  logic      step_en;
  logic      tick_pulse;
  logic      blink_pulse;
  logic      tick_en, tick_clr;
  logic      blink_en, blink_clr;
  edit_sel_e edit_sel;

  // Simultaneous inc and dec cancel out.
  assign step_en = bus.inc_i ^ bus.dec_i;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    unique case (state_q)
      ST_RUN: begin
        if (bus.mode_i) begin
          state_d    = ST_SET_H;
          shadow_d.h = bus.time_h_i;
          shadow_d.m = bus.time_m_i;
          shadow_d.s = bus.time_s_i;
        end
      end
      ST_SET_H: begin
        if (bus.mode_i)   state_d    = ST_SET_M;
        else if (step_en) shadow_d.h = step_h(shadow_q.h, bus.inc_i);
      end
      ST_SET_M: begin
        if (bus.mode_i)   state_d    = ST_SET_S;
        else if (step_en) shadow_d.m = step_ms(shadow_q.m, MAX_M, bus.inc_i);
      end
      ST_SET_S: begin
        if (bus.mode_i)   state_d    = ST_COMMIT;
        else if (step_en) shadow_d.s = step_ms(shadow_q.s, MAX_S, bus.inc_i);
      end
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase

    // Blink phase opens high on entry and runs across all three edit fields.
    blink_d = blink_q;
    if (!is_set(state_d))      blink_d = 1'b0;
    else if (!is_set(state_q)) blink_d = 1'b1;
    else if (blink_pulse)      blink_d = ~blink_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_RUN;
      shadow_q <= '0;
      blink_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      blink_q  <= blink_d;
    end
  end

  // Enables come from registered state so outputs never see the buttons
  // combinationally; clears look ahead so counts sit at zero while idle.
  assign tick_en   = (state_q == ST_RUN);
  assign tick_clr  = (state_d != ST_RUN);
  assign blink_en  = is_set(state_q);
  assign blink_clr = !is_set(state_d);

  relogio_prescaler #(.DIV(CLK_HZ)) u_tick (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (tick_en),
    .clr_i   (tick_clr),
    .pulse_o (tick_pulse)
  );

  relogio_prescaler #(.DIV(BLINK_DIV)) u_blink (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (blink_en),
    .clr_i   (blink_clr),
    .pulse_o (blink_pulse)
  );

  always_comb begin
    edit_sel = SEL_NONE;
    unique case (state_q)
      ST_SET_H: edit_sel = SEL_H;
      ST_SET_M: edit_sel = SEL_M;
      ST_SET_S: edit_sel = SEL_S;
      default:  edit_sel = SEL_NONE;
    endcase
  end

  assign bus.tick_o     = tick_pulse;
  assign bus.load_o     = (state_q == ST_COMMIT);
  assign bus.load_h_o   = shadow_q.h;
  assign bus.load_m_o   = shadow_q.m;
  assign bus.load_s_o   = shadow_q.s;
  assign bus.edit_sel_o = edit_sel;
  assign bus.blink_o    = blink_q;

endmodule

// File: doc/relogio_ctrl.md
# relogio_ctrl

Control and time-setting sequencer for the hours/minutes/seconds timekeeping counter. Generates the 1 Hz advance enable from the system clock and runs a button-driven set mode. In set mode it snapshots the current time, lets the user edit hours, then minutes, then seconds with wrap-around, and writes the result back with a single load strobe. It sits between the debounced button front-end and the timekeeping counter.

## Interface
- CLK_HZ, 100_000_000, system clock cycles per second; tick period.
- BLINK_HZ, 2, blink toggle pairs per second; half-period = CLK_HZ/(2*BLINK_HZ) cycles.
- clk_i  in  1  system clock.
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high.
- mode_i  in  1  single-cycle pulse, debounced upstream; advances set-mode state.
- inc_i  in  1  single-cycle pulse; increment selected field.
- dec_i  in  1  single-cycle pulse; decrement selected field.
- time_h_i  in  5  current hours from counter, 0..23.
- time_m_i  in  6  current minutes, 0..59.
- time_s_i  in  6  current seconds, 0..59.
- tick_o  out  1  one-cycle enable, once per CLK_HZ cycles, RUN only.
- load_o  out  1  one-cycle strobe; counter must take load_*_o.
- load_h_o  out  5  hours to load.
- load_m_o  out  6  minutes to load.
- load_s_o  out  6  seconds to load.
- edit_sel_o  out  2  0 none, 1 hours, 2 minutes, 3 seconds.
- blink_o  out  1  display blink phase for selected field; 0 in RUN.

## Operation
- States: RUN, SET_H, SET_M, SET_S, COMMIT.
- RUN: prescaler counts 0..CLK_HZ-1; tick_o=1 in the cycle the count equals CLK_HZ-1, then count wraps to 0. mode_i -> SET_H; shadow regs capture time_*_i in that same cycle.
- SET_H -> SET_M -> SET_S on mode_i. SET_S + mode_i -> COMMIT. COMMIT -> RUN unconditionally after one cycle.
- In SET_x: inc_i adds 1 to selected shadow field, dec_i subtracts 1, modulo 24 (hours) or 60 (min/sec). 23+1=0, 0-1=23, 59+1=0, 0-1=59.
- inc_i and dec_i in the same cycle: no change. mode_i has priority: with mode_i asserted, inc/dec are ignored that cycle.
- inc/dec in RUN or COMMIT: ignored.
- Prescaler is held at 0 and tick_o=0 in all set states and COMMIT. Time therefore does not advance during editing.
- COMMIT: load_o=1 for exactly that cycle. load_*_o = shadow regs. load_*_o hold the shadow values at all times.
- Blink counter runs only in SET_x. blink_o toggles every CLK_HZ/(2*BLINK_HZ) cycles and starts at 1 on entry to SET_H. Counter and blink_o are cleared in RUN and COMMIT.
- Reset mid-edit: returns to RUN with no load. Edits are discarded.

## Timing
- Reset values: state RUN, prescaler 0, blink counter 0, shadow 0. tick_o, load_o, blink_o, edit_sel_o all 0. load_*_o 0.
- All outputs registered or decoded from registered state only; no input-to-output combinational path.
- First tick_o after reset or after COMMIT: CLK_HZ cycles later, counting from the first RUN cycle.
- mode_i at cycle n: new state and edit_sel_o visible at n+1. Edited shadow value visible on load_*_o at n+1 after inc/dec.
- Latency from final mode_i (in SET_S) to load_o: 1 cycle. Return to RUN: 2 cycles.
- Prescaler width $clog2(CLK_HZ). Shadow widths match the port widths. Wrap compare uses the full field width, with no truncation.

## Structure
- Package relogio_pkg: state enum; edit_sel encodings; MAX_H=23, MAX_M=59, MAX_S=59; field width constants 5/6.
- One sub-module, relogio_prescaler. Parameter DIV; ports clk_i, rst_i, en_i, clr_i, pulse_o. It is instantiated twice: tick (DIV=CLK_HZ) and blink (DIV=CLK_HZ/(2*BLINK_HZ)).
- Modulo up/down for each field is a function in relogio_pkg.

## Test plan
Run all scenarios with CLK_HZ=10, BLINK_HZ=1.
- Reset, idle RUN for 35 cycles -> tick_o pulses at cycles 10, 20, 30. load_o never asserts. blink_o=0.
- time_h_i=23, m=59, s=59; mode, inc in SET_H; mode, inc in SET_M; mode, inc in SET_S; mode -> single load_o with h=0, m=0, s=0.
- time=00:00:00; enter SET_H, dec, then three mode pulses -> load_h_o=23, m=0, s=0. No tick_o between entry and COMMIT.
- inc_i and dec_i together in SET_M -> minutes unchanged. mode_i and inc_i together in SET_H -> state becomes SET_M, hours unchanged.
- Assert rst_i asynchronously mid-SET_M -> state RUN and outputs at reset values immediately. No load_o afterwards.
- In SET_H, hold 12 cycles -> blink_o toggles every 5 cycles, starting at 1. After COMMIT -> blink_o=0, and the first tick_o comes 10 cycles after re-entering RUN.
